// File: rtl/qspi_reg_arb.sv
// qspi_reg_arb: two-port round-robin write arbiter that owns the QSPI
// controller configuration register bank (NREG = 2**AW registers of DW bits,
// reset to all ones), with a flattened register view and a registered read port.
//
// Handshake: a port raises mK_req with stable mK_addr/mK_wdata and holds them
// until it sees the one-cycle mK_gnt pulse; the write lands at the edge that
// ends the gnt cycle, and the port may drop or replace its request right after.
//
// Optional feature macro: QSPI_REG_ARB_LOCK_EN (port ownership lock). When it
// is undefined, m0_lock/m1_lock are ignored and arbitration is pure round robin.
module qspi_reg_arb #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [AW-1:0]         m0_addr,
  input  logic [DW-1:0]         m0_wdata,
  input  logic                  m0_lock,
  output logic                  m0_gnt,
  input  logic                  m1_req,
  input  logic [AW-1:0]         m1_addr,
  input  logic [DW-1:0]         m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  input  logic [AW-1:0]         rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic [(2**AW)*DW-1:0] reg_q,
  output logic                  busy
);
  localparam int NREG = 2**AW;

  logic            elig0, elig1;
  logic            sel0, sel1;
  logic            last;       // 1: port 1 was granted most recently
  logic            busy_next;
  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] load_en;
  logic [DW-1:0]   wr_data;

`ifdef QSPI_REG_ARB_LOCK_EN
  logic own_vld, own_id, own_active, own_vld_next, own_id_next;
`else
  logic unused_lock;
  assign unused_lock = m0_lock | m1_lock;
`endif

  // Eligibility, round-robin pick and next ownership / busy.
  always_comb begin
    // A port is not eligible in its own gnt cycle so a held request is not
    // granted twice while the requester is about to deassert.
    elig0 = m0_req & ~m0_gnt;
    elig1 = m1_req & ~m1_gnt;
`ifdef QSPI_REG_ARB_LOCK_EN
    own_active = own_vld & (own_id ? m1_lock : m0_lock);
    if (own_active) begin
      if (own_id) elig0 = 1'b0;
      else        elig1 = 1'b0;
    end
`endif
    sel0 = elig0 & (~elig1 | last);
    sel1 = elig1 & (~elig0 | ~last);
`ifdef QSPI_REG_ARB_LOCK_EN
    // Ownership drops as soon as the owner's lock is seen low.
    own_vld_next = own_active;
    own_id_next  = own_id;
    if (sel0 & m0_lock) begin
      own_vld_next = 1'b1;
      own_id_next  = 1'b0;
    end else if (sel1 & m1_lock) begin
      own_vld_next = 1'b1;
      own_id_next  = 1'b1;
    end
    busy_next = sel0 | sel1 | own_vld_next;
`else
    busy_next = sel0 | sel1;
`endif
  end

  // Grant pulses, round-robin pointer and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      last   <= 1'b1;
      busy   <= 1'b0;
    end else begin
      m0_gnt <= sel0;
      m1_gnt <= sel1;
      busy   <= busy_next;
      if (sel0)      last <= 1'b0;
      else if (sel1) last <= 1'b1;
    end
  end

`ifdef QSPI_REG_ARB_LOCK_EN
  // Lock owner register.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_vld <= 1'b0;
      own_id  <= 1'b0;
    end else begin
      own_vld <= own_vld_next;
      own_id  <= own_id_next;
    end
  end
`endif

  // Per-register load enables decoded from the granted port's held address.
  always_comb begin
    load_en = '0;
    for (int i = 0; i < NREG; i++) begin
      load_en[i] = (m0_gnt && (m0_addr == AW'(i))) ||
                   (m1_gnt && (m1_addr == AW'(i)));
    end
    wr_data = m1_gnt ? m1_wdata : m0_wdata;
  end

  // Register bank; reset wins over a write issued in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '1;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (load_en[i]) regs[i] <= wr_data;
      end
    end
  end

  // Registered read port; a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '1;
    else     rd_data <= regs[rd_addr];
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_q[g*DW +: DW] = regs[g];
  end

endmodule
